// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, state encodings, datapath select codes and the control-word layout
// for the multicycle MIPS controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StAddiEx = 4'd8,
    StAddiWb = 4'd9,
    StBranch = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BGTZ  = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BGTZ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational control-word decode from the current state (plus mem_ready/op where
// an output depends on them). Encodings 12-15 decode to an all-zero word.
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_e'(state_i))
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      StDecode: begin
        ctrl_o.alu_src_b  = SRCB_IMM_SH2;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.illegal_op = !op_supported(op_i);
      end
      StMemAdr, StAddiEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StMemRd: begin
        ctrl_o.ior_d    = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      StMemWb: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StMemWr: begin
        ctrl_o.ior_d      = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      StExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      StRwb: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StAddiWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALUOP_BGTZ;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register and next-state logic; output decode lives
// in multicycle_ctrl_decode. Write enables and pulses are masked while rst is high.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] state_q, state_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_e'(state_q))
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (op)
          OP_RTYPE:     state_d = StExec;
          OP_ADDI:      state_d = StAddiEx;
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_BGTZ:      state_d = StBranch;
          OP_J:         state_d = StJump;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (op == OP_LW) ? StMemRd : StMemWr;
      StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
      StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
      StExec:   state_d = StRwb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .state_i     (state_q),
    .op_i        (op),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write & ~rst;
  assign PCWriteCond = ctrl.pc_write_cond & ~rst;
  assign IRWrite     = ctrl.ir_write & ~rst;
  assign MemWrite    = ctrl.mem_write & ~rst;
  assign RegWrite    = ctrl.reg_write & ~rst;
  assign instr_done  = ctrl.instr_done & ~rst;
  assign illegal_op  = ctrl.illegal_op & ~rst;
  assign IorD        = ctrl.ior_d;
  assign MemRead     = ctrl.mem_read;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table for the instruction sequences and
// reset corners, then random op/mem_ready/rst against an instruction-path reference model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst, mem_ready;
  logic [5:0] op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst;
  logic       RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .state       (state)
  );

  logic [21:0] dut_vec;
  assign dut_vec = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
                    illegal_op};

  logic [11:0] dut_key;
  assign dut_key = {state, RegWrite, instr_done, illegal_op, MemWrite, PCWrite, PCWriteCond,
                    PCSource};

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
    logic       rw, dn, il, mw, pcw, pcwc;
    logic [1:0] pcs;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [5:0] o, input logic mr, input logic [3:0] st,
                     input logic rw, input logic dn, input logic il, input logic mw,
                     input logic pcw, input logic pcwc, input logic [1:0] pcs);
    vec_t v;
    v = '{rst: r, op: o, mr: mr, st: st, rw: rw, dn: dn, il: il, mw: mw, pcw: pcw,
          pcwc: pcwc, pcs: pcs};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Reference model: the current step of the instruction plus a queue of the steps still
  // to come, chosen when the opcode is examined.
  int m_cur;
  int m_q[$];

  function automatic logic [21:0] model_out(int cur, logic mr, logic [5:0] o, logic r);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, dn, ill;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, dn, ill} = '0;
    {asb, aop, pcs} = '0;
    case (cur)
      0:  begin mrd = 1; asb = 2'd1; pcw = mr; irw = mr; end
      1:  begin
            asb = 2'd3;
            ill = !(o == 6'h00 || o == 6'h08 || o == 6'h23 || o == 6'h2B || o == 6'h07 ||
                    o == 6'h02);
          end
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin iord = 1; mrd = 1; end
      4:  begin m2r = 1; rw = 1; dn = 1; end
      5:  begin iord = 1; mwr = 1; dn = mr; end
      6:  begin asa = 1; aop = 2'd2; end
      7:  begin rdst = 1; rw = 1; dn = 1; end
      8:  begin asa = 1; asb = 2'd2; end
      9:  begin rw = 1; dn = 1; end
      10: begin asa = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; dn = 1; end
      11: begin pcw = 1; pcs = 2'd2; dn = 1; end
      default: ;
    endcase
    if (r) {pcw, pcwc, irw, mwr, rw, dn, ill} = '0;
    return {4'(cur), pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, dn, ill};
  endfunction

  task automatic advance();
    m_cur = (m_q.size() > 0) ? m_q.pop_front() : 0;
  endtask

  task automatic model_step(input logic mr, input logic [5:0] o, input logic r);
    if (r) begin
      m_cur = 0;
      m_q.delete();
      return;
    end
    case (m_cur)
      0: if (mr) m_cur = 1;
      1: begin
        m_q.delete();
        case (o)
          6'h00:        begin m_q.push_back(6); m_q.push_back(7); end
          6'h08:        begin m_q.push_back(8); m_q.push_back(9); end
          6'h23, 6'h2B: m_q.push_back(2);
          6'h07:        m_q.push_back(10);
          6'h02:        m_q.push_back(11);
          default: ;
        endcase
        advance();
      end
      2: begin
        m_q.delete();
        if (o == 6'h23) begin m_q.push_back(3); m_q.push_back(4); end
        else m_q.push_back(5);
        advance();
      end
      3, 5: if (mr) advance();
      default: advance();
    endcase
  endtask

  logic [5:0] legal_ops [6];

  initial begin
    legal_ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h07, 6'h02};

    //  rst op   mr st  rw dn il mw pcw pcwc pcs
    add(1, 6'h00, 1, 0,  0, 0, 0, 0, 0, 0, 2'd0);  // reset masks write enables
    // add, op changes in EXEC are ignored
    add(0, 6'h00, 1, 0,  0, 0, 0, 0, 1, 0, 2'd0);
    add(0, 6'h00, 1, 1,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h3F, 1, 6,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h3F, 1, 7,  1, 1, 0, 0, 0, 0, 2'd0);
    // lw with three wait cycles in MEMRD
    add(0, 6'h23, 1, 0,  0, 0, 0, 0, 1, 0, 2'd0);
    add(0, 6'h23, 1, 1,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h23, 1, 2,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h00, 0, 3,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h00, 0, 3,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h00, 0, 3,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h00, 1, 3,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h00, 1, 4,  1, 1, 0, 0, 0, 0, 2'd0);
    // sw with two wait cycles in MEMWR
    add(0, 6'h2B, 1, 0,  0, 0, 0, 0, 1, 0, 2'd0);
    add(0, 6'h2B, 1, 1,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h2B, 1, 2,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h2B, 0, 5,  0, 0, 0, 1, 0, 0, 2'd0);
    add(0, 6'h2B, 0, 5,  0, 0, 0, 1, 0, 0, 2'd0);
    add(0, 6'h2B, 1, 5,  0, 1, 0, 1, 0, 0, 2'd0);
    // bgtz then j
    add(0, 6'h07, 1, 0,  0, 0, 0, 0, 1, 0, 2'd0);
    add(0, 6'h07, 1, 1,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h07, 1, 10, 0, 1, 0, 0, 0, 1, 2'd1);
    add(0, 6'h02, 1, 0,  0, 0, 0, 0, 1, 0, 2'd0);
    add(0, 6'h02, 1, 1,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h02, 1, 11, 0, 1, 0, 0, 1, 0, 2'd2);
    // illegal opcode
    add(0, 6'h3F, 1, 0,  0, 0, 0, 0, 1, 0, 2'd0);
    add(0, 6'h3F, 1, 1,  0, 0, 1, 0, 0, 0, 2'd0);
    add(0, 6'h3F, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);
    // reset during the second MEMWR wait cycle
    add(0, 6'h2B, 1, 0,  0, 0, 0, 0, 1, 0, 2'd0);
    add(0, 6'h2B, 1, 1,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h2B, 1, 2,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h2B, 0, 5,  0, 0, 0, 1, 0, 0, 2'd0);
    add(1, 6'h2B, 0, 5,  0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 6'h2B, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);

    rst = 1'b1; op = 6'h00; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    // FETCH after reset release, mem_ready low: MemRead=1, ALUSrcB=01, everything else 0
    check("post_reset", dut_vec, {4'd0, 4'b0001, 6'b000000, 2'b01, 2'b00, 2'b00, 2'b00});
    @(posedge clk); #1;

    foreach (vq[i]) begin
      rst = vq[i].rst; op = vq[i].op; mem_ready = vq[i].mr;
      #1;
      check($sformatf("vec%0d", i), {10'd0, dut_key},
            {10'd0, vq[i].st, vq[i].rw, vq[i].dn, vq[i].il, vq[i].mw, vq[i].pcw, vq[i].pcwc,
             vq[i].pcs});
      @(posedge clk); #1;
    end

    rst = 1'b1; mem_ready = 1'b0; op = 6'h00;
    @(posedge clk); #1;
    m_cur = 0;
    m_q.delete();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(63) == 0);
      mem_ready = ($urandom_range(3) != 0);
      op        = ($urandom_range(3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(5)];
      #1;
      check("random", dut_vec, model_out(m_cur, mem_ready, op, rst));
      model_step(mem_ready, op, rst);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for the state register.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 op  in  6  opcode from the instruction register.
REQ-005 mem_ready  in  1  memory handshake: access completes in the cycle it is high.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath enables and selects.
REQ-007 ALUSrcB  out  2  selects 00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-008 ALUOp  out  2  selects 00 add, 01 bgtz compare, 10 R-type funct decode.
REQ-009 PCSource  out  2  selects 00 ALU result, 01 ALUOut register, 10 jump target.
REQ-010 instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
REQ-011 illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
REQ-012 state  out  4  current state encoding, for debug.

Function
REQ-013 The controller SHALL be a 12-state FSM with encodings 0-11: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, ADDI_EX, ADDI_WB, BRANCH, JUMP.
REQ-014 Outputs SHALL be decoded from state, plus mem_ready where stated; every output not listed for a state SHALL be 0.
REQ-015 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH while mem_ready=0; otherwise go to DECODE.
REQ-016 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 and dispatch on op:
  - 000000 -> EXEC; 001000 -> ADDI_EX; 100011 or 101011 -> MEMADR.
  - 000111 -> BRANCH; 000010 -> JUMP.
  - any other op -> FETCH with illegal_op=1.
REQ-017 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD if op=100011, else MEMWR.
REQ-018 MEMRD SHALL drive IorD=1, MemRead=1, hold while mem_ready=0, then go to MEMWB.
REQ-019 MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1, then go to FETCH.
REQ-020 MEMWR SHALL drive IorD=1, MemWrite=1 continuously while waiting.
  - instr_done=mem_ready.
  - Return to FETCH when mem_ready=1.
REQ-021 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RWB.
REQ-022 RWB SHALL drive RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1, then go to FETCH.
REQ-023 ADDI_EX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDI_WB.
REQ-024 ADDI_WB SHALL drive RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1, then go to FETCH.
REQ-025 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1, then go to FETCH.
REQ-026 JUMP SHALL drive PCWrite=1, PCSource=10, instr_done=1, then go to FETCH.
REQ-027 With mem_ready held at 1, cycles per instruction SHALL be: add 4, addi 4, lw 5, sw 4, bgtz 3, j 3.
REQ-028 op SHALL be sampled only in DECODE and MEMADR; op changes in other states SHALL have no effect.
REQ-029 An unused state encoding (12-15) SHALL transition to FETCH and drive all outputs to 0.

Reset
REQ-030 When rst=1 at a rising edge, the state SHALL become FETCH regardless of the current state, including a mid-wait in MEMRD or MEMWR.
REQ-031 While rst=1, PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite, instr_done and illegal_op SHALL be forced to 0.
REQ-032 After reset release, outputs SHALL be the FETCH values: MemRead=1, ALUSrcB=01, state=0, and all other outputs 0 except IRWrite/PCWrite, which follow mem_ready.

Structure
REQ-033 Package mips_ctrl_pkg SHALL hold the following constants:
  - opcodes: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BGTZ, OP_J;
  - the 12 state encodings;
  - the ALUOp, ALUSrcB and PCSource codes.
REQ-034 The block SHALL contain the state register and next-state logic, with output decoding in one combinational sub-module, multicycle_ctrl_decode.

Verification
REQ-035 Reset, then op=000000 with mem_ready=1 -> states 0,1,6,7,0.
  - RegWrite=1 only in the RWB cycle.
  - instr_done pulses once.
REQ-036 op=100011 with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles.
  - MemRead=1 and IorD=1 throughout.
  - Then MEMWB with MemtoReg=1.
REQ-037 op=101011 with mem_ready=0 for 2 cycles in MEMWR -> MemWrite=1 for 3 cycles.
  - instr_done only in the third cycle.
  - RegWrite stays 0.
REQ-038 op=000111, then op=000010 -> 3-cycle sequences.
  - BRANCH: PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
REQ-039 op=111111 -> DECODE then FETCH, with illegal_op=1 for one cycle and no write enables asserted.
REQ-040 rst asserted in the second MEMWR wait cycle -> MemWrite=0 in the rst cycle and state=0 on the next edge.
